// File: rtl/vga_bounce_box.sv
// Bouncing-box pixel generator: two-stage video pipeline plus per-frame box motion.
// Optional macro VGA_BOX_BORDER_EN paints a white one-pixel frame around the active area.
module vga_bounce_box #(
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter int          BOX_SIZE = 32,
   parameter int          SPEED    = 2,
   parameter logic [11:0] BG_RGB   = 12'h008,
   parameter logic [11:0] BOX_RGB0 = 12'hF00,
   parameter logic [11:0] BOX_RGB1 = 12'h0F0,
   parameter logic [11:0] BOX_RGB2 = 12'h00F,
   parameter logic [11:0] BOX_RGB3 = 12'hFF0,
   parameter logic [11:0] BOX_RGB4 = 12'h0FF,
   parameter logic [11:0] BOX_RGB5 = 12'hF0F,
   parameter logic [11:0] BOX_RGB6 = 12'hF80,
   parameter logic [11:0] BOX_RGB7 = 12'h888
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       video_on,
   input  logic       freeze,
   output logic       h_sync_out,
   output logic       v_sync_out,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       frame_tick
);

   generate
      if (BOX_SIZE > V_ACTIVE || SPEED == 0) begin : g_bad_cfg
         $error("vga_bounce_box: BOX_SIZE must not exceed V_ACTIVE and SPEED must be nonzero");
      end
   endgenerate

   localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BOX_SIZE);
   localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0] SPEED_W = 11'(SPEED);
   localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);

   typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} xdir_e;
   typedef enum logic {DOWN  = 1'b0, UP   = 1'b1} ydir_e;

   xdir_e       x_dir_q, x_dir_d;
   ydir_e       y_dir_q, y_dir_d;
   logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
   logic [2:0]  color_q, color_d;
   logic        v_prev_q, frame_tick_q, frame_tick_d;

   logic        hs1_q, vs1_q, von1_q, in_box1_q, in_box_d;
   logic        hs2_q, vs2_q;
   logic [11:0] rgb_q, rgb_d, box_rgb;

   // Stage 1: box hit test in 11 bits so box_x+BOX_SIZE cannot wrap
   always_comb begin
      logic [10:0] px, py, bx, by;
      px       = {1'b0, pixel_x};
      py       = {1'b0, pixel_y};
      bx       = {1'b0, box_x_q};
      by       = {1'b0, box_y_q};
      in_box_d = (px >= bx) && (px < bx + BOX_W) && (py >= by) && (py < by + BOX_W);
   end

`ifdef VGA_BOX_BORDER_EN
   logic border1_q, border_d;
   always_comb begin
      border_d = (pixel_x == 10'd0) || (pixel_x == 10'(H_ACTIVE - 1)) ||
                 (pixel_y == 10'd0) || (pixel_y == 10'(V_ACTIVE - 1));
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) border1_q <= 1'b0;
      else      border1_q <= border_d;
   end
`endif

   always_comb begin
      case (color_q)
         3'd0:    box_rgb = BOX_RGB0;
         3'd1:    box_rgb = BOX_RGB1;
         3'd2:    box_rgb = BOX_RGB2;
         3'd3:    box_rgb = BOX_RGB3;
         3'd4:    box_rgb = BOX_RGB4;
         3'd5:    box_rgb = BOX_RGB5;
         3'd6:    box_rgb = BOX_RGB6;
         default: box_rgb = BOX_RGB7;
      endcase
   end

   // Stage 2 colour select
   always_comb begin
      rgb_d = BG_RGB;
      if (!von1_q)        rgb_d = 12'h000;
`ifdef VGA_BOX_BORDER_EN
      else if (border1_q) rgb_d = 12'hFFF;
`endif
      else if (in_box1_q) rgb_d = box_rgb;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         von1_q    <= 1'b0;
         in_box1_q <= 1'b0;
         hs2_q     <= 1'b1;
         vs2_q     <= 1'b1;
         rgb_q     <= 12'h000;
      end else begin
         hs1_q     <= h_sync_in;
         vs1_q     <= v_sync_in;
         von1_q    <= video_on;
         in_box1_q <= in_box_d;
         hs2_q     <= hs1_q;
         vs2_q     <= vs1_q;
         rgb_q     <= rgb_d;
      end
   end

   assign frame_tick_d = !v_sync_in && v_prev_q;

   // Motion FSMs; updates only land on the frame_tick cycle, inside vertical blanking
   always_comb begin
      logic [10:0] x_sum, y_sum;
      logic        x_clamp, y_clamp;
      x_dir_d = x_dir_q;
      y_dir_d = y_dir_q;
      box_x_d = box_x_q;
      box_y_d = box_y_q;
      color_d = color_q;
      x_clamp = 1'b0;
      y_clamp = 1'b0;
      x_sum   = {1'b0, box_x_q} + SPEED_W;
      y_sum   = {1'b0, box_y_q} + SPEED_W;
      if (frame_tick_q && !freeze) begin
         if (x_dir_q == RIGHT) begin
            if (x_sum >= X_MAX) begin
               box_x_d = X_MAX[9:0];
               x_dir_d = LEFT;
               x_clamp = 1'b1;
            end else box_x_d = x_sum[9:0];
         end else begin
            if ({1'b0, box_x_q} <= SPEED_W) begin
               box_x_d = 10'd0;
               x_dir_d = RIGHT;
               x_clamp = 1'b1;
            end else box_x_d = 10'({1'b0, box_x_q} - SPEED_W);
         end
         if (y_dir_q == DOWN) begin
            if (y_sum >= Y_MAX) begin
               box_y_d = Y_MAX[9:0];
               y_dir_d = UP;
               y_clamp = 1'b1;
            end else box_y_d = y_sum[9:0];
         end else begin
            if ({1'b0, box_y_q} <= SPEED_W) begin
               box_y_d = 10'd0;
               y_dir_d = DOWN;
               y_clamp = 1'b1;
            end else box_y_d = 10'({1'b0, box_y_q} - SPEED_W);
         end
         color_d = color_q + 3'(x_clamp | y_clamp);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_prev_q     <= 1'b1;
         frame_tick_q <= 1'b0;
         x_dir_q      <= RIGHT;
         y_dir_q      <= DOWN;
         box_x_q      <= 10'd0;
         box_y_q      <= 10'd0;
         color_q      <= 3'd0;
      end else begin
         v_prev_q     <= v_sync_in;
         frame_tick_q <= frame_tick_d;
         x_dir_q      <= x_dir_d;
         y_dir_q      <= y_dir_d;
         box_x_q      <= box_x_d;
         box_y_q      <= box_y_d;
         color_q      <= color_d;
      end
   end

   assign h_sync_out = hs2_q;
   assign v_sync_out = vs2_q;
   assign red        = rgb_q[11:8];
   assign green      = rgb_q[7:4];
   assign blue       = rgb_q[3:0];
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: latency, colour select, wall/corner bounce, freeze, reset.
module tb_vga_bounce_box;
   logic       gclk = 1'b0;
   logic       grst_n;
   logic       hs, vs, von, frz;
   logic [9:0] px, py;
   logic       hs_o, vs_o, ft;
   logic [3:0] r, g, b;
   logic       sq_hs_o, sq_vs_o, sq_ft;
   logic [3:0] sq_r, sq_g, sq_b;

   int nvec = 0;
   int nerr = 0;
   int ticks = 0;

   always #5 gclk = ~gclk;

   vga_bounce_box dut (
      .clk(gclk), .rst(grst_n), .h_sync_in(hs), .v_sync_in(vs), .pixel_x(px), .pixel_y(py),
      .video_on(von), .freeze(frz), .h_sync_out(hs_o), .v_sync_out(vs_o),
      .red(r), .green(g), .blue(b), .frame_tick(ft)
   );

   // square playfield so both axes clamp on the same frame
   vga_bounce_box #(.H_ACTIVE(96), .V_ACTIVE(96), .BOX_SIZE(32), .SPEED(3)) dut_sq (
      .clk(gclk), .rst(grst_n), .h_sync_in(hs), .v_sync_in(vs), .pixel_x(px), .pixel_y(py),
      .video_on(von), .freeze(frz), .h_sync_out(sq_hs_o), .v_sync_out(sq_vs_o),
      .red(sq_r), .green(sq_g), .blue(sq_b), .frame_tick(sq_ft)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic v,
                      input logic [11:0] exp);
      px = 10'(x); py = 10'(y); von = v;
      @(negedge gclk);
      von = 1'b0;
      @(negedge gclk);
      chk(tag, {20'd0, r, g, b}, {20'd0, exp});
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         vs = 1'b0;
         @(negedge gclk); if (ft) ticks++;
         vs = 1'b1;
         @(negedge gclk); if (ft) ticks++;
         @(negedge gclk); if (ft) ticks++;
      end
   endtask

   initial begin
      grst_n = 1'b0; hs = 1'b1; vs = 1'b1; von = 1'b0; frz = 1'b0; px = '0; py = '0;
      repeat (2) @(negedge gclk);
      chk("rst_hs", 32'(hs_o), 32'd1);
      chk("rst_vs", 32'(vs_o), 32'd1);
      chk("rst_rgb", {20'd0, r, g, b}, 32'h0);
      chk("rst_ft", 32'(ft), 32'd0);
      grst_n = 1'b1;
      repeat (2) @(negedge gclk);

      // exactly two cycles of latency on colour and sync
      px = 10'd5; py = 10'd5; von = 1'b1;
      @(negedge gclk); von = 1'b0;
      chk("lat_c1", {20'd0, r, g, b}, 32'h000);
      @(negedge gclk);
      chk("lat_c2", {20'd0, r, g, b}, 32'hF00);
      @(negedge gclk);
      chk("lat_c3", {20'd0, r, g, b}, 32'h000);
      hs = 1'b0;
      @(negedge gclk); hs = 1'b1;
      chk("hs_c1", 32'(hs_o), 32'd1);
      @(negedge gclk);
      chk("hs_c2", 32'(hs_o), 32'd0);
      @(negedge gclk);
      chk("hs_c3", 32'(hs_o), 32'd1);

      pix("bg",       100, 100, 1'b1, 12'h008);
      pix("box_edge",  31,  31, 1'b1, 12'hF00);
      pix("x_out",     32,   5, 1'b1, 12'h008);
      pix("y_out",      5,  32, 1'b1, 12'h008);
      pix("blank700", 700,   5, 1'b0, 12'h000);
      pix("blankbox",   5,   5, 1'b0, 12'h000);

      // first frame: one-cycle tick, then position moves
      vs = 1'b0;
      @(negedge gclk); vs = 1'b1;
      chk("ft_hi", 32'(ft), 32'd1);
      @(negedge gclk);
      chk("ft_lo", 32'(ft), 32'd0);
      chk("f1_x", 32'(dut.box_x_q), 32'd2);
      chk("f1_y", 32'(dut.box_y_q), 32'd2);
      @(negedge gclk);

      frames(20);
      chk("sq21_x", 32'(dut_sq.box_x_q), 32'd63);
      chk("sq21_c", 32'(dut_sq.color_q), 32'd0);
      frames(1);
      chk("sq22_x", 32'(dut_sq.box_x_q), 32'd64);
      chk("sq22_y", 32'(dut_sq.box_y_q), 32'd64);
      chk("sq22_xd", 32'(dut_sq.x_dir_q), 32'd1);
      chk("sq22_yd", 32'(dut_sq.y_dir_q), 32'd1);
      chk("sq22_c", 32'(dut_sq.color_q), 32'd1);
      chk("f22_x", 32'(dut.box_x_q), 32'd44);

      frames(281);
      chk("f303_x", 32'(dut.box_x_q), 32'd606);
      chk("f303_y", 32'(dut.box_y_q), 32'd290);
      chk("f303_c", 32'(dut.color_q), 32'd1);
      chk("f303_yd", 32'(dut.y_dir_q), 32'd1);
      pix("p303_tl", 606, 290, 1'b1, 12'h0F0);
      pix("p303_l",  605, 290, 1'b1, 12'h008);
      pix("p303_br", 637, 321, 1'b1, 12'h0F0);
      pix("p303_r",  638, 290, 1'b1, 12'h008);

      frames(1);
      chk("wall_x", 32'(dut.box_x_q), 32'd608);
      chk("wall_xd", 32'(dut.x_dir_q), 32'd1);
      chk("wall_c", 32'(dut.color_q), 32'd2);
      chk("wall_y", 32'(dut.box_y_q), 32'd288);
      pix("wall_p",  639, 288, 1'b1, 12'h00F);
      pix("wall_pl", 607, 288, 1'b1, 12'h008);

      frz = 1'b1; ticks = 0;
      frames(3);
      chk("frz_ticks", 32'(ticks), 32'd3);
      chk("frz_x", 32'(dut.box_x_q), 32'd608);
      chk("frz_y", 32'(dut.box_y_q), 32'd288);
      chk("frz_c", 32'(dut.color_q), 32'd2);
      frz = 1'b0;

      // asynchronous reset between clock edges
      px = 10'd620; py = 10'd300; von = 1'b1; hs = 1'b0;
      repeat (3) @(negedge gclk);
      chk("pre_rst_rgb", {20'd0, r, g, b}, 32'h00F);
      #2 grst_n = 1'b0;
      #1;
      chk("mrst_hs", 32'(hs_o), 32'd1);
      chk("mrst_rgb", {20'd0, r, g, b}, 32'h000);
      chk("mrst_x", 32'(dut.box_x_q), 32'd0);
      chk("mrst_c", 32'(dut.color_q), 32'd0);
      von = 1'b0; hs = 1'b1;
      @(negedge gclk); grst_n = 1'b1;
      ticks = 0;
      repeat (10) begin
         @(negedge gclk); if (ft) ticks++;
      end
      chk("post_rst_noft", 32'(ticks), 32'd0);
      vs = 1'b0;
      @(negedge gclk); vs = 1'b1;
      chk("post_rst_ft", 32'(ft), 32'd1);
      @(negedge gclk);
      chk("post_rst_x", 32'(dut.box_x_q), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
